instr_sequencer: RTL and testbench

//  Multi-cycle control sequencer for the single-bus datapath. Fetches an instruction,

---
 rtl/instr_sequencer.sv | 154 +++++++++++++++
 tb/tb_instr_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch into IR, step decoder control words until next step 00.
// Optional SEQ_PERF_CNT_EN adds retired_cnt / stall_cnt performance counters.
module instr_sequencer #(
  parameter int unsigned CW_W      = 31,
  parameter int unsigned MAX_STEPS = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr_in,
  output logic            fetch_req,
  output logic [31:0]     instruction,
  output logic [1:0]      state,
  input  logic [CW_W-1:0] cw_in,
  input  logic [1:0]      next_state_in,
  input  logic            mem_ready,
  input  logic            halt_req,
  output logic [CW_W-1:0] controlWord,
  output logic            busy,
  output logic            halted,
`ifdef SEQ_PERF_CNT_EN
  output logic [31:0]     retired_cnt,
  output logic [31:0]     stall_cnt,
`endif
  output logic            seq_error
);

  localparam int unsigned CNT_W   = $clog2(MAX_STEPS) + 1;
  localparam int unsigned PSEL_HI = 30;
  localparam int unsigned PSEL_LO = 29;
  localparam int unsigned REGW    = 8;
  localparam int unsigned RAMW    = 7;
  localparam int unsigned EN_MEM  = 6;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} fsm_t;

  fsm_t             fsm;
  logic [31:0]      ir;
  logic [1:0]       step;
  logic [CNT_W-1:0] step_cnt;
  logic             err;
  logic             busy_q;
  logic             halted_q;
  logic             mem_wait_c;

  assign mem_wait_c  = (fsm == S_EXEC) && (cw_in[EN_MEM] || cw_in[RAMW]) && !mem_ready;
  assign fetch_req   = (fsm == S_FETCH);
  assign instruction = ir;
  assign state       = step;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign seq_error   = err;

  // Pass decoder word through in EXEC; suppress register write-back and bus select while stalled
  always_comb begin
    controlWord = '0;
    if (fsm == S_EXEC) begin
      controlWord = cw_in;
      if (mem_wait_c) begin
        controlWord[REGW]            = 1'b0;
        controlWord[PSEL_HI:PSEL_LO] = 2'b00;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm      <= S_IDLE;
      ir       <= '0;
      step     <= 2'b00;
      step_cnt <= '0;
      err      <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (halt_req) begin
            fsm      <= S_HALTED;
            halted_q <= 1'b1;
          end else begin
            fsm <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (instr_valid) begin
            ir       <= instr_in;
            step     <= 2'b00;
            step_cnt <= '0;
            fsm      <= S_EXEC;
            busy_q   <= 1'b1;
          end else if (halt_req) begin
            fsm      <= S_HALTED;
            halted_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (!mem_wait_c) begin
            if (next_state_in == 2'b00) begin
              step     <= 2'b00;
              step_cnt <= '0;
              busy_q   <= 1'b0;
              if (halt_req) begin
                fsm      <= S_HALTED;
                halted_q <= 1'b1;
              end else begin
                fsm <= S_FETCH;
              end
            end else if (step_cnt == CNT_W'(MAX_STEPS - 1)) begin
              // Runaway decoder sequence: flag and abandon the instruction
              err      <= 1'b1;
              step     <= 2'b00;
              step_cnt <= '0;
              busy_q   <= 1'b0;
              fsm      <= S_FETCH;
            end else begin
              step     <= next_state_in;
              step_cnt <= step_cnt + CNT_W'(1);
            end
          end
        end
        S_HALTED: begin
          if (!halt_req) begin
            fsm      <= S_FETCH;
            halted_q <= 1'b0;
          end
        end
        default: begin
          fsm      <= S_IDLE;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic retire_c;

  assign retire_c = (fsm == S_EXEC) && !mem_wait_c && (next_state_in == 2'b00);

  // Free-running counters, wrap modulo 2^32
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (retire_c)   retired_cnt <= retired_cnt + 32'd1;
      if (mem_wait_c) stall_cnt   <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: per-cycle vector table with an expected-output scoreboard queue.
module tb_instr_sequencer;

  localparam int unsigned CW_W = 31;
  localparam int unsigned NV   = 26;

  logic            clock;
  logic            reset_n;
  logic            instr_valid;
  logic [31:0]     instr_in;
  logic            fetch_req;
  logic [31:0]     instruction;
  logic [1:0]      state;
  logic [CW_W-1:0] cw_in;
  logic [1:0]      next_state_in;
  logic            mem_ready;
  logic            halt_req;
  logic [CW_W-1:0] controlWord;
  logic            busy;
  logic            halted;
  logic            seq_error;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]     retired_cnt;
  logic [31:0]     stall_cnt;
`endif

  instr_sequencer #(.CW_W(CW_W), .MAX_STEPS(4)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .instr_valid   (instr_valid),
    .instr_in      (instr_in),
    .fetch_req     (fetch_req),
    .instruction   (instruction),
    .state         (state),
    .cw_in         (cw_in),
    .next_state_in (next_state_in),
    .mem_ready     (mem_ready),
    .halt_req      (halt_req),
    .controlWord   (controlWord),
    .busy          (busy),
    .halted        (halted),
`ifdef SEQ_PERF_CNT_EN
    .retired_cnt   (retired_cnt),
    .stall_cnt     (stall_cnt),
`endif
    .seq_error     (seq_error)
  );

  typedef struct {
    logic            fr;
    logic            bz;
    logic            ht;
    logic            er;
    logic [1:0]      st;
    logic [CW_W-1:0] cw;
    logic [31:0]     ir;
  } exp_t;

  typedef struct {
    logic            iv;
    logic [31:0]     instr;
    logic [CW_W-1:0] cw;
    logic [1:0]      nx;
    logic            mr;
    logic            hl;
    exp_t            e;
  } vec_t;

  exp_t exp_q[$];
  vec_t vec[NV];
  int   total = 0;
  int   bad   = 0;

  localparam logic [CW_W-1:0] CT = 31'h5000_0002;
  localparam logic [CW_W-1:0] CA = 31'h0000_0020;
  localparam logic [CW_W-1:0] CB = 31'h6000_0140;
  localparam logic [CW_W-1:0] BM = 31'h0000_0040;
  localparam logic [CW_W-1:0] CC = 31'h0000_0108;
  localparam logic [CW_W-1:0] CR = 31'h0000_0080;
  localparam logic [31:0] I1 = 32'hD61F_0000;
  localparam logic [31:0] I2 = 32'h1234_5678;
  localparam logic [31:0] I3 = 32'hAAAA_0001;
  localparam logic [31:0] I4 = 32'h0F0F_0F0F;
  localparam logic [31:0] I5 = 32'h5555_AAAA;
  localparam logic [31:0] I6 = 32'h8000_0080;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t mke(input logic fr, bz, ht, er, input logic [1:0] st,
                               input logic [CW_W-1:0] cw, input logic [31:0] ir);
    exp_t e;
    e.fr = fr; e.bz = bz; e.ht = ht; e.er = er; e.st = st; e.cw = cw; e.ir = ir;
    return e;
  endfunction

  function automatic vec_t mkv(input logic iv, input logic [31:0] instr, input logic [CW_W-1:0] cw,
                               input logic [1:0] nx, input logic mr, hl, input exp_t e);
    vec_t v;
    v.iv = iv; v.instr = instr; v.cw = cw; v.nx = nx; v.mr = mr; v.hl = hl; v.e = e;
    return v;
  endfunction

  task automatic check(input string nm);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = exp_q.pop_front();
    if ({fetch_req, busy, halted, seq_error, state, controlWord, instruction} !==
        {e.fr, e.bz, e.ht, e.er, e.st, e.cw, e.ir}) begin
      bad++;
      $display("FAIL %s: got fr=%0b bz=%0b ht=%0b er=%0b st=%0d cw=%h ir=%h, want fr=%0b bz=%0b ht=%0b er=%0b st=%0d cw=%h ir=%h",
               nm, fetch_req, busy, halted, seq_error, state, controlWord, instruction,
               e.fr, e.bz, e.ht, e.er, e.st, e.cw, e.ir);
    end
  endtask

  task automatic drive(input vec_t v);
    instr_valid   = v.iv;
    instr_in      = v.instr;
    cw_in         = v.cw;
    next_state_in = v.nx;
    mem_ready     = v.mr;
    halt_req      = v.hl;
  endtask

  task automatic apply(input vec_t v, input string nm);
    @(posedge clock);
    #1;
    drive(v);
    exp_q.push_back(v.e);
    @(negedge clock);
    check(nm);
  endtask

`ifdef SEQ_PERF_CNT_EN
  task automatic check_perf(input string nm, input logic [31:0] r, input logic [31:0] s);
    total++;
    if (retired_cnt !== r || stall_cnt !== s) begin
      bad++;
      $display("FAIL %s: got retired=%0d stall=%0d, want retired=%0d stall=%0d",
               nm, retired_cnt, stall_cnt, r, s);
    end
  endtask
`endif

  initial begin
    // fetch + single-step retire
    vec[0]  = mkv(1, I1, CT, 2'd0, 1, 0, mke(1, 0, 0, 0, 2'd0, '0, '0));
    vec[1]  = mkv(0, '0, CT, 2'd0, 1, 0, mke(0, 1, 0, 0, 2'd0, CT, I1));
    vec[2]  = mkv(0, '0, '0, 2'd0, 1, 0, mke(1, 0, 0, 0, 2'd0, '0, I1));
    // 3-step load with two memory wait cycles on step 1
    vec[3]  = mkv(1, I2, CA, 2'd1, 1, 0, mke(1, 0, 0, 0, 2'd0, '0, I1));
    vec[4]  = mkv(0, '0, CA, 2'd1, 1, 0, mke(0, 1, 0, 0, 2'd0, CA, I2));
    vec[5]  = mkv(0, '0, CB, 2'd2, 0, 0, mke(0, 1, 0, 0, 2'd1, BM, I2));
    vec[6]  = mkv(0, '0, CB, 2'd2, 0, 0, mke(0, 1, 0, 0, 2'd1, BM, I2));
    vec[7]  = mkv(0, '0, CB, 2'd2, 1, 0, mke(0, 1, 0, 0, 2'd1, CB, I2));
    vec[8]  = mkv(0, '0, CC, 2'd0, 1, 0, mke(0, 1, 0, 0, 2'd2, CC, I2));
    vec[9]  = mkv(0, '0, '0, 2'd0, 1, 0, mke(1, 0, 0, 0, 2'd0, '0, I2));
    // runaway sequence: four EXEC cycles then abort with sticky error
    vec[10] = mkv(1, I3, CA, 2'd1, 1, 0, mke(1, 0, 0, 0, 2'd0, '0, I2));
    vec[11] = mkv(0, '0, CA, 2'd1, 1, 0, mke(0, 1, 0, 0, 2'd0, CA, I3));
    vec[12] = mkv(0, '0, CA, 2'd1, 1, 0, mke(0, 1, 0, 0, 2'd1, CA, I3));
    vec[13] = mkv(0, '0, CA, 2'd1, 1, 0, mke(0, 1, 0, 0, 2'd1, CA, I3));
    vec[14] = mkv(0, '0, CA, 2'd1, 1, 0, mke(0, 1, 0, 0, 2'd1, CA, I3));
    vec[15] = mkv(0, '0, '0, 2'd0, 1, 0, mke(1, 0, 0, 1, 2'd0, '0, I3));
    // halt on last step, then halt from FETCH, then valid beats halt
    vec[16] = mkv(1, I4, CT, 2'd0, 1, 0, mke(1, 0, 0, 1, 2'd0, '0, I3));
    vec[17] = mkv(0, '0, CT, 2'd0, 1, 1, mke(0, 1, 0, 1, 2'd0, CT, I4));
    vec[18] = mkv(0, '0, CB, 2'd2, 0, 1, mke(0, 0, 1, 1, 2'd0, '0, I4));
    vec[19] = mkv(0, '0, CB, 2'd2, 0, 0, mke(0, 0, 1, 1, 2'd0, '0, I4));
    vec[20] = mkv(0, '0, '0, 2'd0, 1, 1, mke(1, 0, 0, 1, 2'd0, '0, I4));
    vec[21] = mkv(0, '0, '0, 2'd0, 1, 0, mke(0, 0, 1, 1, 2'd0, '0, I4));
    vec[22] = mkv(1, I5, CT, 2'd0, 1, 1, mke(1, 0, 0, 1, 2'd0, '0, I4));
    vec[23] = mkv(0, '0, CT, 2'd0, 1, 0, mke(0, 1, 0, 1, 2'd0, CT, I5));
    // store stalled on memory, reset hits mid-EXEC afterwards
    vec[24] = mkv(1, I6, '0, 2'd0, 1, 0, mke(1, 0, 0, 1, 2'd0, '0, I5));
    vec[25] = mkv(0, '0, CR, 2'd1, 0, 0, mke(0, 1, 0, 1, 2'd0, CR, I6));

    reset_n = 1'b0;
    drive(mkv(0, '0, '0, 2'd0, 0, 0, mke(0, 0, 0, 0, 2'd0, '0, '0)));
    #12;
    exp_q.push_back(mke(0, 0, 0, 0, 2'd0, '0, '0));
    check("reset");
`ifdef SEQ_PERF_CNT_EN
    check_perf("perf_reset", 32'd0, 32'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    drive(vec[0]);
    #1;
    exp_q.push_back(mke(0, 0, 0, 0, 2'd0, '0, '0));
    check("idle");

    for (int i = 0; i < NV; i++) begin
      apply(vec[i], $sformatf("vec%0d", i));
`ifdef SEQ_PERF_CNT_EN
      if (i == 9)  check_perf("perf_after_load", 32'd2, 32'd2);
      if (i == 15) check_perf("perf_after_abort", 32'd2, 32'd2);
`endif
    end

    // asynchronous reset in the middle of the stalled store
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.push_back(mke(0, 0, 0, 0, 2'd0, '0, '0));
    check("async_reset");
    @(posedge clock);
    @(negedge clock);
    reset_n  = 1'b1;
    halt_req = 1'b1;
    #1;
    exp_q.push_back(mke(0, 0, 0, 0, 2'd0, '0, '0));
    check("idle_halt");
    @(posedge clock);
    #1;
    exp_q.push_back(mke(0, 0, 1, 0, 2'd0, '0, '0));
    check("idle_to_halted");
    halt_req    = 1'b0;
    instr_valid = 1'b0;
    @(posedge clock);
    #1;
    exp_q.push_back(mke(1, 0, 0, 0, 2'd0, '0, '0));
    check("halted_to_fetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
